// File: rtl/irq_ctl_pkg.sv
// Shared constants for the irq_ctl interrupt controller.
// Register offsets, the VECTOR idle code and register reset values.
package irq_ctl_pkg;

  localparam logic [2:0] OFF_PEND   = 3'd0;
  localparam logic [2:0] OFF_ENABLE = 3'd1;
  localparam logic [2:0] OFF_CLEAR  = 3'd2;
  localparam logic [2:0] OFF_EDGE   = 3'd3;
  localparam logic [2:0] OFF_POL    = 3'd4;
  localparam logic [2:0] OFF_VECTOR = 3'd5;
  localparam logic [2:0] OFF_SET    = 3'd6;
  localparam logic [2:0] OFF_RSVD   = 3'd7;

  localparam logic [7:0] VECTOR_NONE = 8'h80;

  localparam logic [7:0] ENABLE_RST = 8'h00;
  localparam logic [7:0] EDGE_RST   = 8'h00;
  localparam logic [7:0] POL_RST    = 8'h00;

endpackage

// File: rtl/irq_ctl_src.sv
// One interrupt source: synchronizer, edge/level detect, pending bit.
// A set (event or SET write) beats a same-cycle clear.
module irq_src (
  input  logic clk,
  input  logic reset_n,
  input  logic src,
  input  logic pol,
  input  logic edge_en,
  input  logic setw,
  input  logic clrw,
  output logic pend
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic act, evt;

  // Current pol on both sides, so a pol flip alone is not an edge.
  assign act = s2_q ^ pol;
  assign evt = act & ~(prev_q ^ pol);

  always_comb begin
    s1_d   = src;
    s2_d   = s1_q;
    prev_d = s2_q;
    if (edge_en)
      pend_d = evt | setw | (pend_q & ~clrw);
    else
      pend_d = act;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/irq_ctl.sv
// Memory-mapped interrupt controller on the 65C02 synchronous bus.
// Registered read data, per-source pending bits and a registered irq.
module irq_ctl #(
  parameter logic [15:0] BASE = 16'hFE00,
  parameter int          NSRC = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     AB,
  input  logic            WE,
  input  logic [7:0]      DO,
  output logic [7:0]      rdata,
  output logic            rsel,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  import irq_ctl_pkg::*;

  logic            hit, rd, wr;
  logic [2:0]      off;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [NSRC-1:0] pol_q, pol_d;
  logic [NSRC-1:0] pend, pe, setw, clrw;
  logic [7:0]      rdata_q, rdata_d;
  logic            rsel_q, rsel_d;
  logic            irq_q, irq_d;
  logic [7:0]      pend8, en8, edge8, pol8, vec, rval;

  assign hit = AB[15:3] == BASE[15:3];
  assign off = AB[2:0];
  assign wr  = hit & WE;
  assign rd  = hit & ~WE;
  assign pe  = pend & enable_q;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_src u_src (
      .clk     (clk),
      .reset_n (reset_n),
      .src     (src[i]),
      .pol     (pol_q[i]),
      .edge_en (edge_q[i]),
      .setw    (setw[i]),
      .clrw    (clrw[i]),
      .pend    (pend[i])
    );
  end

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    pol_d    = pol_q;
    setw     = '0;
    clrw     = '0;
    if (wr) begin
      unique case (off)
        OFF_ENABLE: enable_d = DO[NSRC-1:0];
        OFF_EDGE:   edge_d   = DO[NSRC-1:0];
        OFF_POL:    pol_d    = DO[NSRC-1:0];
        OFF_CLEAR:  clrw     = DO[NSRC-1:0];
        OFF_SET:    setw     = DO[NSRC-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    pend8 = '0;
    en8   = '0;
    edge8 = '0;
    pol8  = '0;
    pend8[NSRC-1:0] = pend;
    en8[NSRC-1:0]   = enable_q;
    edge8[NSRC-1:0] = edge_q;
    pol8[NSRC-1:0]  = pol_q;
  end

  // Walk high to low so the lowest pending source wins.
  always_comb begin
    vec = VECTOR_NONE;
    for (int i = NSRC - 1; i >= 0; i--)
      if (pe[i]) vec = {5'd0, i[2:0]};
  end

  always_comb begin
    rval = 8'h00;
    unique case (off)
      OFF_PEND:   rval = pend8;
      OFF_ENABLE: rval = en8;
      OFF_CLEAR:  rval = pend8;
      OFF_EDGE:   rval = edge8;
      OFF_POL:    rval = pol8;
      OFF_VECTOR: rval = vec;
      OFF_SET:    rval = 8'h00;
      OFF_RSVD:   rval = 8'h00;
    endcase
    rdata_d = rd ? rval : 8'h00;
    rsel_d  = rd;
    irq_d   = |pe;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_q <= ENABLE_RST[NSRC-1:0];
      edge_q   <= EDGE_RST[NSRC-1:0];
      pol_q    <= POL_RST[NSRC-1:0];
      rdata_q  <= 8'h00;
      rsel_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      edge_q   <= edge_d;
      pol_q    <= pol_d;
      rdata_q  <= rdata_d;
      rsel_q   <= rsel_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign rsel  = rsel_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: a register table plus
// hand-written multi-cycle interrupt sequences.
module tb_irq_ctl;

  localparam logic [15:0] BASE = 16'hFE00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic [7:0]  rdata;
  logic        rsel;
  logic [7:0]  src;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  irq_ctl #(.BASE(BASE), .NSRC(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .AB      (AB),
    .WE      (WE),
    .DO      (DO),
    .rdata   (rdata),
    .rsel    (rsel),
    .src     (src),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [2:0] off;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    AB = 16'h0000;
    WE = 1'b0;
    DO = 8'h00;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    AB = BASE + {13'd0, off};
    WE = 1'b1;
    DO = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [2:0] off, input logic [7:0] exp,
                    input string name);
    AB = BASE + {13'd0, off};
    WE = 1'b0;
    tick();
    chk({name, ".rsel"}, {7'd0, rsel}, 8'h01);
    chk(name, rdata, exp);
    idle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 3'd0, 8'h00, 8'h00, "rst_pend"};
    tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h00, "rst_enable"};
    tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'h00, "rst_clear"};
    tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'h00, "rst_edge"};
    tbl[4]  = '{1'b0, 3'd4, 8'h00, 8'h00, "rst_pol"};
    tbl[5]  = '{1'b0, 3'd5, 8'h00, 8'h80, "rst_vector"};
    tbl[6]  = '{1'b0, 3'd6, 8'h00, 8'h00, "rst_set"};
    tbl[7]  = '{1'b0, 3'd7, 8'h00, 8'h00, "rst_rsvd"};
    tbl[8]  = '{1'b1, 3'd1, 8'h5A, 8'h00, "wr_enable"};
    tbl[9]  = '{1'b0, 3'd1, 8'h00, 8'h5A, "rb_enable"};
    tbl[10] = '{1'b1, 3'd3, 8'hC3, 8'h00, "wr_edge"};
    tbl[11] = '{1'b0, 3'd3, 8'h00, 8'hC3, "rb_edge"};
    tbl[12] = '{1'b1, 3'd7, 8'hFF, 8'h00, "wr_rsvd"};
    tbl[13] = '{1'b0, 3'd7, 8'h00, 8'h00, "rb_rsvd"};
    tbl[14] = '{1'b1, 3'd5, 8'hFF, 8'h00, "wr_vector"};
    tbl[15] = '{1'b0, 3'd5, 8'h00, 8'h80, "rb_vector"};
    tbl[16] = '{1'b1, 3'd0, 8'hFF, 8'h00, "wr_pend"};
    tbl[17] = '{1'b0, 3'd0, 8'h00, 8'h00, "rb_pend"};

    reset_n = 1'b0;
    src = 8'h00;
    idle();
    tick();
    do_reset();
    tick();
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_rsel", {7'd0, rsel}, 8'h00);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        wr(tbl[i].off, tbl[i].data);
        chk({tbl[i].name, ".rsel"}, {7'd0, rsel}, 8'h00);
      end else begin
        rd(tbl[i].off, tbl[i].exp, tbl[i].name);
      end
    end
    chk("tbl_irq", {7'd0, irq}, 8'h00);

    // Edge source 0: latency, vector, clear, no retrigger.
    do_reset();
    wr(3'd1, 8'h01);
    wr(3'd3, 8'h01);
    src[0] = 1'b1;
    tick();
    tick();
    rd(3'd0, 8'h00, "t2_pend_e3");
    chk("t2_irq_e3", {7'd0, irq}, 8'h00);
    rd(3'd0, 8'h01, "t2_pend_e4");
    chk("t2_irq_e4", {7'd0, irq}, 8'h01);
    rd(3'd5, 8'h00, "t2_vector");
    wr(3'd2, 8'h01);
    chk("t2_irq_clr0", {7'd0, irq}, 8'h01);
    tick();
    chk("t2_irq_clr1", {7'd0, irq}, 8'h00);
    repeat (5) tick();
    rd(3'd0, 8'h00, "t2_noretrig");
    chk("t2_irq_end", {7'd0, irq}, 8'h00);

    // Level source 2, active-low.
    do_reset();
    src = 8'h00;
    repeat (3) tick();
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h04);
    wr(3'd1, 8'h04);
    tick();
    rd(3'd0, 8'h04, "t3_pend");
    chk("t3_irq", {7'd0, irq}, 8'h01);
    rd(3'd5, 8'h02, "t3_vector");
    wr(3'd2, 8'h04);
    rd(3'd0, 8'h04, "t3_clr_noeff");
    wr(3'd6, 8'h02);
    rd(3'd0, 8'h04, "t3_set_noeff");
    src[2] = 1'b1;
    tick();
    tick();
    tick();
    chk("t3_irq_e3", {7'd0, irq}, 8'h01);
    rd(3'd0, 8'h00, "t3_pend_off");
    chk("t3_irq_e4", {7'd0, irq}, 8'h00);
    rd(3'd5, 8'h80, "t3_vec_none");

    // Edge event beats a same-cycle CLEAR; SET on edge source.
    do_reset();
    src = 8'h00;
    repeat (3) tick();
    wr(3'd3, 8'h03);
    wr(3'd1, 8'h03);
    src[1] = 1'b1;
    tick();
    tick();
    wr(3'd2, 8'h02);
    rd(3'd0, 8'h02, "t4_set_beats_clr");
    wr(3'd6, 8'h01);
    rd(3'd0, 8'h03, "t4_setw");
    rd(3'd5, 8'h00, "t4_vector");
    wr(3'd6, 8'h04);
    rd(3'd0, 8'h03, "t4_set_level");
    wr(3'd2, 8'h03);
    rd(3'd0, 8'h00, "t4_clr_both");

    // POL toggle on a steady edge source never makes an event.
    do_reset();
    src = 8'h00;
    repeat (3) tick();
    wr(3'd3, 8'h08);
    src[3] = 1'b1;
    repeat (4) tick();
    rd(3'd0, 8'h08, "t5_rise");
    wr(3'd2, 8'h08);
    rd(3'd0, 8'h00, "t5_cleared");
    wr(3'd4, 8'h08);
    repeat (4) tick();
    rd(3'd0, 8'h00, "t5_pol_1");
    wr(3'd4, 8'h00);
    repeat (4) tick();
    rd(3'd0, 8'h00, "t5_pol_0");

    // Reset kills an in-flight read and discards a write.
    do_reset();
    wr(3'd1, 8'hFF);
    AB = BASE + 16'd1;
    WE = 1'b0;
    tick();
    chk("t6_rd_rsel", {7'd0, rsel}, 8'h01);
    chk("t6_rd_data", rdata, 8'hFF);
    reset_n = 1'b0;
    tick();
    chk("t6_rst_rsel", {7'd0, rsel}, 8'h00);
    chk("t6_rst_data", rdata, 8'h00);
    idle();
    reset_n = 1'b1;
    rd(3'd1, 8'h00, "t6_enable_rst");
    reset_n = 1'b0;
    wr(3'd1, 8'h55);
    reset_n = 1'b1;
    rd(3'd1, 8'h00, "t6_wr_discard");
    AB = BASE + 16'd8;
    tick();
    chk("t6_out_hi_rsel", {7'd0, rsel}, 8'h00);
    chk("t6_out_hi_data", rdata, 8'h00);
    AB = BASE - 16'd1;
    tick();
    chk("t6_out_lo_rsel", {7'd0, rsel}, 8'h00);
    AB = BASE + 16'd8;
    WE = 1'b1;
    DO = 8'hAA;
    tick();
    idle();
    rd(3'd1, 8'h00, "t6_out_wr");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
